// File: rtl/boreal_policy_vm.sv
// boreal_policy_vm: walks mailbox words, clamps each, emits gate actions.
// Optional nonce echo check: define BOREAL_VM_NONCE_CHECK_EN.
module boreal_policy_vm #(
  parameter int          MB_WORDS    = 4,
  parameter logic [31:0] CLAMP_MAX   = 32'd100,
  parameter logic [31:0] TARGET_BASE = 32'h0000_0010,
  parameter logic [31:0] OPCODE      = 32'd1,
  parameter logic [31:0] POLICY_HASH = 32'hA5A5_0001,
  parameter int          BUDGET      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [32*MB_WORDS-1:0]  mb_ai,
  input  logic                    start,
  output logic                    act_valid,
  output logic [511:0]            act_data,
  input  logic                    gate_resp_valid,
  input  logic [159:0]            gate_resp_data,
  output logic                    done,
  output logic                    timeout,
  output logic                    nonce_err,
  output logic [7:0]              deny_cnt
);

  localparam int IW = (MB_WORDS > 1) ? $clog2(MB_WORDS) : 1;
  localparam int BW = $clog2(BUDGET + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLAMP,
    S_EMIT,
    S_WAIT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic [31:0]    r0_q, r0_d;
  logic [31:0]    r1_q, r1_d;
  logic [31:0]    nonce_q, nonce_d;
  logic [7:0]     deny_q, deny_d;
  logic           done_q, done_d;
  logic           tmo_q, tmo_d;
  logic           nerr_q, nerr_d;
  logic           av_q, av_d;
  logic [511:0]   ad_q, ad_d;

  logic [31:0]    words [MB_WORDS];
  logic           active;
  logic           abort;
  logic           resp_ok;
  logic           bad_nonce;
  logic           last;
  logic           unused_resp;

  for (genvar g = 0; g < MB_WORDS; g++) begin : g_words
    assign words[g] = mb_ai[32*g +: 32];
  end

  assign active  = (state_q == S_LOAD) || (state_q == S_CLAMP) ||
                   (state_q == S_EMIT) || (state_q == S_WAIT);
  assign abort   = start && active && (bcnt_q == BW'(BUDGET));
  assign resp_ok = start && (state_q == S_WAIT) &&
                   gate_resp_valid && !abort;
  assign last    = (idx_q == IW'(MB_WORDS - 1));

`ifdef BOREAL_VM_NONCE_CHECK_EN
  assign bad_nonce   = resp_ok && (gate_resp_data[31:0] != nonce_q);
  assign unused_resp = ^gate_resp_data[159:33];
`else
  assign bad_nonce   = 1'b0;
  assign unused_resp = ^{gate_resp_data[159:33], gate_resp_data[31:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Budget abort overrides every other transition of an active run.
  always_comb begin
    state_d = state_q;
    if (!start) begin
      state_d = S_IDLE;
    end else if (abort) begin
      state_d = S_DONE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_LOAD;
        S_LOAD:  state_d = S_CLAMP;
        S_CLAMP: state_d = S_EMIT;
        S_EMIT:  state_d = S_WAIT;
        S_WAIT: begin
          if (resp_ok) begin
            state_d = (bad_nonce || last) ? S_DONE : S_LOAD;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    nonce_d = nonce_q;
    deny_d  = deny_q;
    tmo_d   = tmo_q;
    nerr_d  = nerr_q;
    av_d    = 1'b0;
    ad_d    = ad_q;
    if (!start) begin
      tmo_d  = 1'b0;
      nerr_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          idx_d  = '0;
          bcnt_d = '0;
          deny_d = '0;
          tmo_d  = 1'b0;
          nerr_d = 1'b0;
        end
        S_LOAD: begin
          r0_d = words[idx_q];
        end
        S_CLAMP: begin
          r1_d = (r0_q > CLAMP_MAX) ? CLAMP_MAX : r0_q;
        end
        S_EMIT: begin
          if (!abort) begin
            av_d            = 1'b1;
            ad_d            = '0;
            ad_d[31:0]      = OPCODE;
            ad_d[63:32]     = TARGET_BASE + 32'(idx_q);
            ad_d[95:64]     = r1_q;
            ad_d[191:160]   = POLICY_HASH;
            ad_d[255:224]   = nonce_q;
          end
        end
        S_WAIT: begin
          if (resp_ok && !bad_nonce) begin
            nonce_d = nonce_q + 32'd1;
            if (!gate_resp_data[32] && (deny_q != 8'hFF)) begin
              deny_d = deny_q + 8'd1;
            end
            if (!last) begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: ;
      endcase
      if (active && !abort) begin
        bcnt_d = bcnt_q + BW'(1);
      end
      if (abort) begin
        tmo_d = 1'b1;
      end
      if (bad_nonce) begin
        nerr_d = 1'b1;
      end
    end
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      bcnt_q  <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      nonce_q <= '0;
      deny_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      nerr_q  <= 1'b0;
      av_q    <= 1'b0;
      ad_q    <= '0;
    end else begin
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      nonce_q <= nonce_d;
      deny_q  <= deny_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      nerr_q  <= nerr_d;
      av_q    <= av_d;
      ad_q    <= ad_d;
    end
  end

  assign act_valid = av_q;
  assign act_data  = ad_q;
  assign done      = done_q;
  assign timeout   = tmo_q;
  assign nonce_err = nerr_q;
  assign deny_cnt  = deny_q;

endmodule

// File: tb/tb_boreal_policy_vm.sv
// Directed bench for boreal_policy_vm with default parameters.
// Responses are driven in the first WAIT cycle (4-cycle words).
module tb_boreal_policy_vm;

  logic         clk;
  logic         rst_n;
  logic [127:0] mb_ai;
  logic         start;
  logic         act_valid;
  logic [511:0] act_data;
  logic         gate_resp_valid;
  logic [159:0] gate_resp_data;
  logic         done;
  logic         timeout;
  logic         nonce_err;
  logic [7:0]   deny_cnt;

  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;
  int n0;
  int extra;
  int k;

  logic [31:0] arg_a [4] = '{32'd0, 32'd7, 32'd100, 32'd100};
  logic [31:0] arg_d [4] = '{32'd5, 32'd99, 32'd100, 32'd100};
  bit          den_b [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  boreal_policy_vm dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mb_ai           (mb_ai),
    .start           (start),
    .act_valid       (act_valid),
    .act_data        (act_data),
    .gate_resp_valid (gate_resp_valid),
    .gate_resp_data  (gate_resp_data),
    .done            (done),
    .timeout         (timeout),
    .nonce_err       (nonce_err),
    .deny_cnt        (deny_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] act_word(input int i,
                                            input logic [31:0] arg,
                                            input logic [31:0] nonce);
    logic [511:0] w;
    w          = '0;
    w[31:0]    = 32'd1;
    w[63:32]   = 32'h10 + 32'(i);
    w[95:64]   = arg;
    w[191:160] = 32'hA5A5_0001;
    w[255:224] = nonce;
    return w;
  endfunction

  // Wait for a pulse, check it, optionally answer in the same cycle.
  task automatic serve(input int i, input logic [31:0] arg,
                       input logic [31:0] nonce, input bit allow,
                       input logic [31:0] echo, input int exp_cyc,
                       input bit respond);
    int w;
    w = 0;
    while (!act_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!act_valid) begin
      chk("pulse_seen", act_valid, 1);
    end else begin
      chk($sformatf("pulse_cyc_w%0d", i), cyc, exp_cyc);
      chk($sformatf("act_data_w%0d", i), act_data,
          act_word(i, arg, nonce));
      chk($sformatf("done_busy_w%0d", i), done, 0);
      if (respond) begin
        gate_resp_valid      = 1'b1;
        gate_resp_data       = '0;
        gate_resp_data[31:0] = echo;
        gate_resp_data[32]   = allow;
        @(negedge clk);
        gate_resp_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    gate_resp_valid = 1'b0;
    gate_resp_data  = '0;
    mb_ai           = {32'd400, 32'd100, 32'd7, 32'd0};
    repeat (2) @(negedge clk);
    chk("rst_act_valid", act_valid, 0);
    chk("rst_act_data", act_data, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_nonce_err", nonce_err, 0);
    chk("rst_deny_cnt", deny_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Run A: all allowed
    start = 1'b1;
    n0 = cyc + 1;
    for (int i = 0; i < 4; i++)
      serve(i, arg_a[i], 32'(i), 1'b1, 32'(i), n0 + 3 + 4 * i, 1'b1);
    chk("a_done", done, 1);
    chk("a_done_cyc", cyc, n0 + 16);
    chk("a_deny", deny_cnt, 0);
    chk("a_timeout", timeout, 0);
    start = 1'b0;
    @(negedge clk);
    chk("a_done_clr", done, 0);

    // Run B: words 1 and 3 denied
    start = 1'b1;
    n0 = cyc + 1;
    for (int i = 0; i < 4; i++)
      serve(i, arg_a[i], 32'(4 + i), den_b[i], 32'(4 + i),
            n0 + 3 + 4 * i, 1'b1);
    chk("b_deny", deny_cnt, 2);
    chk("b_done", done, 1);
    chk("b_timeout", timeout, 0);
    start = 1'b0;
    @(negedge clk);
    chk("b_deny_kept", deny_cnt, 2);
    chk("b_done_clr", done, 0);

    // Run C: gate silent, budget abort
    start = 1'b1;
    n0 = cyc + 1;
    serve(0, 32'd0, 32'd8, 1'b1, 32'd8, n0 + 3, 1'b0);
    chk("c_deny_clr", deny_cnt, 0);
    extra = 0;
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      if (act_valid) extra++;
      k++;
    end
    chk("c_done", done, 1);
    chk("c_done_cyc", cyc, n0 + 256);
    chk("c_timeout", timeout, 1);
    chk("c_extra_pulses", extra, 0);
    start = 1'b0;
    @(negedge clk);
    chk("c_timeout_clr", timeout, 0);
    chk("c_done_clr", done, 0);

    // Run D: drop start in WAIT, restart with new words
    start = 1'b1;
    n0 = cyc + 1;
    serve(0, 32'd0, 32'd8, 1'b0, 32'd8, n0 + 3, 1'b1);
    serve(1, 32'd7, 32'd9, 1'b1, 32'd9, n0 + 7, 1'b0);
    start = 1'b0;
    @(negedge clk);
    chk("d_idle_av", act_valid, 0);
    chk("d_idle_done", done, 0);
    chk("d_deny_kept", deny_cnt, 1);
    mb_ai = {32'hFFFF_FFFF, 32'd101, 32'd99, 32'd5};
    start = 1'b1;
    n0 = cyc + 1;
    serve(0, arg_d[0], 32'd9, 1'b1, 32'd9, n0 + 3, 1'b1);
    chk("d_deny_clr", deny_cnt, 0);
    for (int i = 1; i < 4; i++)
      serve(i, arg_d[i], 32'(9 + i), 1'b1, 32'(9 + i),
            n0 + 3 + 4 * i, 1'b1);
    chk("d_done", done, 1);
    start = 1'b0;
    @(negedge clk);

    // Run E: async reset mid-EMIT
    start = 1'b1;
    n0 = cyc + 1;
    serve(0, arg_d[0], 32'd13, 1'b0, 32'd13, n0 + 3, 1'b1);
    chk("e_deny_pre", deny_cnt, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("e_rst_av", act_valid, 0);
    chk("e_rst_ad", act_data, 0);
    chk("e_rst_deny", deny_cnt, 0);
    chk("e_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (act_valid) extra++;
    end
    chk("e_no_pulse", extra, 0);

    // Nonce echo mismatch on nonce 0
    start = 1'b1;
    n0 = cyc + 1;
    serve(0, arg_d[0], 32'd0, 1'b1, 32'd5, n0 + 3, 1'b1);
`ifdef BOREAL_VM_NONCE_CHECK_EN
    chk("n_done", done, 1);
    chk("n_nonce_err", nonce_err, 1);
    start = 1'b0;
    @(negedge clk);
    chk("n_err_clr", nonce_err, 0);
    start = 1'b1;
    n0 = cyc + 1;
    serve(0, arg_d[0], 32'd0, 1'b1, 32'd0, n0 + 3, 1'b1);
`else
    chk("n_done", done, 0);
    serve(1, arg_d[1], 32'd1, 1'b1, 32'd1, n0 + 7, 1'b1);
    serve(2, arg_d[2], 32'd2, 1'b1, 32'd2, n0 + 11, 1'b1);
    serve(3, arg_d[3], 32'd3, 1'b1, 32'd3, n0 + 15, 1'b1);
    chk("n_done_end", done, 1);
    chk("n_nonce_err", nonce_err, 0);
`endif
    start = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
